util_io_filter: RTL and testbench

UTIL_IO_FILTER -- requirements
Module: util_io_filter

---
 rtl/util_io_pkg.sv | 15 +
 rtl/util_io_debounce.sv | 101 ++++++++++
 rtl/util_io_filter.sv | 62 ++++++
 tb/tb_util_io_filter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/util_io_pkg.sv
// Shared constants and types for the GPIO filter slice: pad reset values
// and the per-channel debounce state encoding.
package util_io_pkg;

    localparam int unsigned MAX_PORTS = 32;

    localparam logic [MAX_PORTS-1:0] GPIO_T_RST = 32'hFFFF_FFFF;
    localparam logic [MAX_PORTS-1:0] GPIO_O_RST = 32'h0000_0000;

    typedef enum logic [0:0] {
        DEB_STABLE  = 1'b0,
        DEB_QUALIFY = 1'b1
    } deb_state_e;

endpackage

// File: rtl/util_io_debounce.sv
// One GPIO input channel: synchroniser, debounce FSM with saturating
// counter, and edge detection on the qualified level.
module util_io_debounce
    import util_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pad,
    input  logic [DEBOUNCE_W-1:0] cfg_debounce,
    output logic                  level,
    output logic                  rise,
    output logic                  fall
);

    localparam logic [DEBOUNCE_W-1:0] CNT_ONE  = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};
    localparam logic [DEBOUNCE_W-1:0] CNT_ZERO = {DEBOUNCE_W{1'b0}};
    localparam logic [DEBOUNCE_W-1:0] CNT_MAX  = {DEBOUNCE_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_out_s;
    deb_state_e             state_r;
    deb_state_e             state_nxt_s;
    logic [DEBOUNCE_W-1:0]  cnt_r;
    logic [DEBOUNCE_W-1:0]  cnt_nxt_s;
    logic [DEBOUNCE_W-1:0]  cnt_inc_s;
    logic [DEBOUNCE_W-1:0]  neff_s;
    logic                   level_r;
    logic                   level_nxt_s;
    logic                   prev_r;
    logic                   differ_s;
    logic                   commit_s;

    // Pad synchroniser chain; the last stage feeds the debounce FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pad};
        end
    end

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // The first differing cycle already counts as 1, so a zero setting behaves as 1.
    assign neff_s    = (cfg_debounce == CNT_ZERO) ? CNT_ONE : cfg_debounce;
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
    assign differ_s  = (sync_out_s != level_r);
    assign commit_s  = (cnt_inc_s >= neff_s);

    // FSM state, qualification counter, filtered level and its previous value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DEB_STABLE;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            prev_r  <= level_r;
        end
    end

    // Next-state logic; STABLE keeps cnt_r at zero, so both states share the same decision.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        case (state_r)
            DEB_STABLE, DEB_QUALIFY: begin
                if (!differ_s) begin
                    state_nxt_s = DEB_STABLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (commit_s) begin
                    state_nxt_s = DEB_STABLE;
                    cnt_nxt_s   = CNT_ZERO;
                    level_nxt_s = ~level_r;
                end else begin
                    state_nxt_s = DEB_QUALIFY;
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            default: begin
                state_nxt_s = DEB_STABLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Outputs: qualified level and single-cycle edge strobes.
    always_comb begin
        level = level_r;
        rise  = level_r & ~prev_r;
        fall  = ~level_r & prev_r;
    end

endmodule

// File: rtl/util_io_filter.sv
// GPIO pad wrapper: registered output path, per-channel debounced input
// path, sticky edge-event flags and a registered interrupt.
module util_io_filter
    import util_io_pkg::*;
#(
    parameter int PORT_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PORT_WIDTH-1:0] s_gpio_t,
    input  logic [PORT_WIDTH-1:0] s_gpio_o,
    output logic [PORT_WIDTH-1:0] s_gpio_i,
    output logic [PORT_WIDTH-1:0] gpio_t,
    output logic [PORT_WIDTH-1:0] gpio_o,
    input  logic [PORT_WIDTH-1:0] gpio_i,
    input  logic [DEBOUNCE_W-1:0] cfg_debounce,
    input  logic [PORT_WIDTH-1:0] cfg_rise_en,
    input  logic [PORT_WIDTH-1:0] cfg_fall_en,
    input  logic [PORT_WIDTH-1:0] evt_clr,
    output logic [PORT_WIDTH-1:0] evt_flag,
    output logic                  irq
);

    logic [PORT_WIDTH-1:0] rise_s;
    logic [PORT_WIDTH-1:0] fall_s;
    logic [PORT_WIDTH-1:0] evt_set_s;

    for (genvar g = 0; g < PORT_WIDTH; g++) begin : gen_ch
        util_io_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
        ) u_deb (
            .clk          (clk),
            .rst          (rst),
            .pad          (gpio_i[g]),
            .cfg_debounce (cfg_debounce),
            .level        (s_gpio_i[g]),
            .rise         (rise_s[g]),
            .fall         (fall_s[g])
        );
    end

    assign evt_set_s = (rise_s & cfg_rise_en) | (fall_s & cfg_fall_en);

    // Pad output registers, sticky event flags (set beats clear) and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_t   <= GPIO_T_RST[PORT_WIDTH-1:0];
            gpio_o   <= GPIO_O_RST[PORT_WIDTH-1:0];
            evt_flag <= {PORT_WIDTH{1'b0}};
            irq      <= 1'b0;
        end else begin
            gpio_t   <= s_gpio_t;
            gpio_o   <= s_gpio_o;
            evt_flag <= evt_set_s | (evt_flag & ~evt_clr);
            irq      <= |evt_flag;
        end
    end

endmodule

// File: tb/tb_util_io_filter.sv
// Directed self-checking bench for util_io_filter (PORT_WIDTH 8, SYNC_STAGES 2).
module tb_util_io_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_gpio_t;
    logic [7:0]  s_gpio_o;
    logic [7:0]  s_gpio_i;
    logic [7:0]  gpio_t;
    logic [7:0]  gpio_o;
    logic [7:0]  gpio_i;
    logic [15:0] cfg_debounce;
    logic [7:0]  cfg_rise_en;
    logic [7:0]  cfg_fall_en;
    logic [7:0]  evt_clr;
    logic [7:0]  evt_flag;
    logic        irq;

    int checks = 0;
    int errors = 0;

    util_io_filter #(
        .PORT_WIDTH  (8),
        .SYNC_STAGES (2),
        .DEBOUNCE_W  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_gpio_t     (s_gpio_t),
        .s_gpio_o     (s_gpio_o),
        .s_gpio_i     (s_gpio_i),
        .gpio_t       (gpio_t),
        .gpio_o       (gpio_o),
        .gpio_i       (gpio_i),
        .cfg_debounce (cfg_debounce),
        .cfg_rise_en  (cfg_rise_en),
        .cfg_fall_en  (cfg_fall_en),
        .evt_clr      (evt_clr),
        .evt_flag     (evt_flag),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until s_gpio_i[idx] reaches val; -1 if the bound expires.
    task automatic wait_level(input int idx, input logic val, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (s_gpio_i[idx] === val) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; s_gpio_t = 8'h00; s_gpio_o = 8'hFF; gpio_i = 8'h00;
        cfg_debounce = 16'd4; cfg_rise_en = 8'h00; cfg_fall_en = 8'h00; evt_clr = 8'h00;
        tick(2);
        checks++; if (gpio_t !== 8'hFF) begin errors++; $display("FAIL reset_gpio_t got %h want ff", gpio_t); end
        checks++; if (gpio_o !== 8'h00) begin errors++; $display("FAIL reset_gpio_o got %h want 00", gpio_o); end
        checks++; if (s_gpio_i !== 8'h00) begin errors++; $display("FAIL reset_s_gpio_i got %h want 00", s_gpio_i); end
        checks++; if (evt_flag !== 8'h00) begin errors++; $display("FAIL reset_evt_flag got %h want 00", evt_flag); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        rst = 1'b0;
    endtask

    task automatic test_output;
        s_gpio_o = 8'h00; s_gpio_t = 8'hFF;
        tick(1);
        s_gpio_o = 8'hA5; s_gpio_t = 8'h0F;
        #2;
        checks++; if (gpio_o !== 8'h00) begin errors++; $display("FAIL out_latency_o got %h want 00", gpio_o); end
        checks++; if (gpio_t !== 8'hFF) begin errors++; $display("FAIL out_latency_t got %h want ff", gpio_t); end
        tick(1);
        checks++; if (gpio_o !== 8'hA5) begin errors++; $display("FAIL out_gpio_o got %h want a5", gpio_o); end
        checks++; if (gpio_t !== 8'h0F) begin errors++; $display("FAIL out_gpio_t got %h want 0f", gpio_t); end
    endtask

    task automatic test_step;
        int lat;
        cfg_debounce = 16'd4;
        gpio_i[0] = 1'b1;
        wait_level(0, 1'b1, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL step_rise_latency got %0d want 6", lat); end
        gpio_i[0] = 1'b0;
        wait_level(0, 1'b0, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL step_fall_latency got %0d want 6", lat); end
    endtask

    task automatic test_glitch;
        logic seen;
        cfg_debounce = 16'd4; cfg_rise_en = 8'hFF;
        seen = 1'b0;
        gpio_i[3] = 1'b1;
        tick(3);
        gpio_i[3] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen = seen | s_gpio_i[3] | evt_flag[3];
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_rejected got 1 want 0"); end
        cfg_rise_en = 8'h00;
    endtask

    task automatic test_events;
        int lat;
        cfg_debounce = 16'd4; cfg_rise_en = 8'h01; cfg_fall_en = 8'h00;
        gpio_i[0] = 1'b1;
        wait_level(0, 1'b1, lat);
        checks++; if (evt_flag !== 8'h00) begin errors++; $display("FAIL evt_not_yet got %h want 00", evt_flag); end
        tick(1);
        checks++; if (evt_flag !== 8'h01) begin errors++; $display("FAIL evt_rise_set got %h want 01", evt_flag); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b want 0", irq); end
        tick(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
        gpio_i[0] = 1'b0;
        wait_level(0, 1'b0, lat);
        tick(2);
        checks++; if (evt_flag !== 8'h01) begin errors++; $display("FAIL evt_after_fall got %h want 01", evt_flag); end
        evt_clr = 8'h01;
        tick(1);
        evt_clr = 8'h00;
        checks++; if (evt_flag !== 8'h00) begin errors++; $display("FAIL evt_clear got %h want 00", evt_flag); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_clear_latency got %b want 1", irq); end
        tick(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
        // Rise strobe is live now; clear lands on the same edge as the set.
        gpio_i[0] = 1'b1;
        wait_level(0, 1'b1, lat);
        evt_clr = 8'h01;
        tick(1);
        evt_clr = 8'h00;
        checks++; if (evt_flag !== 8'h01) begin errors++; $display("FAIL evt_set_wins got %h want 01", evt_flag); end
        cfg_rise_en = 8'h00;
        tick(1);
        checks++; if (evt_flag !== 8'h01) begin errors++; $display("FAIL evt_enable_change got %h want 01", evt_flag); end
        gpio_i[0] = 1'b0;
        wait_level(0, 1'b0, lat);
        evt_clr = 8'hFF;
        tick(1);
        evt_clr = 8'h00;
        tick(1);
    endtask

    task automatic test_bypass;
        int lat;
        cfg_debounce = 16'd0;
        gpio_i[1] = 1'b1;
        wait_level(1, 1'b1, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL bypass0_rise got %0d want 3", lat); end
        gpio_i[1] = 1'b0;
        wait_level(1, 1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL bypass0_fall got %0d want 3", lat); end
        cfg_debounce = 16'd1;
        gpio_i[1] = 1'b1;
        wait_level(1, 1'b1, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL bypass1_rise got %0d want 3", lat); end
        gpio_i[1] = 1'b0;
        wait_level(1, 1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL bypass1_fall got %0d want 3", lat); end
    endtask

    task automatic test_reset_mid;
        int  lat;
        logic seen;
        cfg_debounce = 16'd0; cfg_rise_en = 8'hFF; cfg_fall_en = 8'h00;
        gpio_i = 8'hFF;
        wait_level(7, 1'b1, lat);
        tick(1);
        checks++; if (evt_flag !== 8'hFF) begin errors++; $display("FAIL mid_flags_set got %h want ff", evt_flag); end
        cfg_debounce = 16'd8;
        gpio_i = 8'h00;
        tick(4);
        rst = 1'b1;
        tick(1);
        checks++; if (gpio_t !== 8'hFF) begin errors++; $display("FAIL mid_rst_gpio_t got %h want ff", gpio_t); end
        checks++; if (gpio_o !== 8'h00) begin errors++; $display("FAIL mid_rst_gpio_o got %h want 00", gpio_o); end
        checks++; if (s_gpio_i !== 8'h00) begin errors++; $display("FAIL mid_rst_s_gpio_i got %h want 00", s_gpio_i); end
        checks++; if (evt_flag !== 8'h00) begin errors++; $display("FAIL mid_rst_evt_flag got %h want 00", evt_flag); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq got %b want 0", irq); end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            seen = seen | (|evt_flag) | (|s_gpio_i) | irq;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_event got 1 want 0"); end
        // Pad held high through reset must qualify as a normal rise afterwards.
        cfg_debounce = 16'd4;
        gpio_i[2] = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        wait_level(2, 1'b1, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL held_high_latency got %0d want 6", lat); end
        tick(1);
        checks++; if (evt_flag !== 8'h04) begin errors++; $display("FAIL held_high_event got %h want 04", evt_flag); end
    endtask

    initial begin
        test_reset;
        test_output;
        test_step;
        test_glitch;
        test_events;
        test_bypass;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
